// File: rtl/hub75_bcm_driver.sv
// Double-buffered HUB75 scan driver with binary-code modulation.
// Optional HUB75_BRIGHTNESS_EN adds an 8-bit global dimming input.
module hub75_bcm_driver #(
   parameter int WIDTH        = 64,
   parameter int HEIGHT       = 32,
   parameter int CHAINED      = 1,
   parameter int COLOR_BITS   = 4,
   parameter int BASE_TICKS   = 8,
   parameter int LATCH_CYCLES = 2,
   localparam int COLS   = WIDTH * CHAINED,
   localparam int ROW_W  = $clog2(HEIGHT / 2),
   localparam int ADDR_W = $clog2(COLS * HEIGHT)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_wr_en,
   input  logic [ADDR_W-1:0]       i_wr_addr,
   input  logic [3*COLOR_BITS-1:0] i_wr_data,
   input  logic                    i_swap_req,
`ifdef HUB75_BRIGHTNESS_EN
   input  logic [7:0]              i_brightness,
`endif
   output logic                    o_swap_ack,
   output logic                    o_frame_start,
   output logic                    o_sclk,
   output logic                    o_lat,
   output logic                    o_oe,
   output logic [2:0]              o_rgb0,
   output logic [2:0]              o_rgb1,
   output logic [ROW_W-1:0]        o_row_select
);

   localparam int ROWS     = HEIGHT / 2;
   localparam int HALF     = COLS * ROWS;
   localparam int NPIX     = COLS * HEIGHT;
   localparam int CB       = COLOR_BITS;
   localparam int PIX_W    = 3 * CB;
   localparam int MEM_D    = 2 * HALF;
   localparam int MEM_AW   = $clog2(MEM_D);
   localparam int PL_W     = (CB > 1) ? $clog2(CB) : 1;
   localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int SH_LAST  = 2 * COLS;
   localparam int DISP_MAX = BASE_TICKS << (CB - 1);
   localparam int MAX_A    = (SH_LAST > LATCH_CYCLES) ? SH_LAST : LATCH_CYCLES;
   localparam int MAX_C    = (MAX_A > DISP_MAX) ? MAX_A : DISP_MAX;
   localparam int CNT_W    = $clog2(MAX_C + 1);

   typedef enum logic [1:0] {
      S_SHIFT,
      S_BLANK,
      S_LATCH,
      S_DISP
   } state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [ROW_W-1:0]  row, row_n, row_sel_q;
   logic [PL_W-1:0]   plane, plane_n;
   logic              front, back, pend;
   logic              frame_end, swap_fire, oe_on;
   logic [CNT_W-1:0]  disp_len, disp_last;
   logic [PIX_W-1:0]  top_q, bot_q;

   logic [PIX_W-1:0]  mem_top [MEM_D];
   logic [PIX_W-1:0]  mem_bot [MEM_D];

   // Host port: always targets the bank not being scanned
   logic              wr_ok, wr_top;
   logic [31:0]       wr_off;
   logic [MEM_AW-1:0] wr_idx;

   assign back   = ~front;
   assign wr_ok  = 32'(i_wr_addr) < 32'(NPIX);
   assign wr_top = 32'(i_wr_addr) < 32'(HALF);
   assign wr_off = 32'(i_wr_addr) - (wr_top ? 32'd0 : 32'(HALF));
   assign wr_idx = MEM_AW'(32'(back) * 32'(HALF) + wr_off);

   always_ff @(posedge i_clk) begin
      if (i_wr_en && wr_ok) begin
         if (wr_top) mem_top[wr_idx] <= i_wr_data;
         else        mem_bot[wr_idx] <= i_wr_data;
      end
   end

   // Scan read runs one cycle ahead of the shift data phase
   logic              rd_en;
   logic [COL_W-1:0]  rd_col;
   logic [MEM_AW-1:0] rd_idx;

   assign rd_en  = (state == S_SHIFT) && !cnt[0] &&
                   (cnt != CNT_W'(SH_LAST));
   assign rd_col = COL_W'(cnt >> 1);
   assign rd_idx = MEM_AW'(32'(front) * 32'(HALF) +
                   32'(row) * 32'(COLS) + 32'(rd_col));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         top_q <= '0;
         bot_q <= '0;
      end else if (rd_en) begin
         top_q <= mem_top[rd_idx];
         bot_q <= mem_bot[rd_idx];
      end
   end

   assign disp_len  = CNT_W'(BASE_TICKS) << plane;
   assign disp_last = disp_len - 1'b1;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      row_n     = row;
      plane_n   = plane;
      frame_end = 1'b0;
      unique case (state)
         S_SHIFT: begin
            if (cnt == CNT_W'(SH_LAST)) begin
               state_n = S_BLANK;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_BLANK: begin
            state_n = S_LATCH;
            cnt_n   = '0;
         end
         S_LATCH: begin
            if (cnt == CNT_W'(LATCH_CYCLES - 1)) begin
               state_n = S_DISP;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_DISP: begin
            if (cnt == disp_last) begin
               state_n = S_SHIFT;
               cnt_n   = '0;
               if (plane == PL_W'(CB - 1)) begin
                  plane_n = '0;
                  if (row == ROW_W'(ROWS - 1)) begin
                     row_n     = '0;
                     frame_end = 1'b1;
                  end else begin
                     row_n = row + 1'b1;
                  end
               end else begin
                  plane_n = plane + 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = S_SHIFT;
      endcase
   end

   // A request arriving on the frame-end cycle itself is honoured there
   assign swap_fire = frame_end && (pend || i_swap_req);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= S_SHIFT;
         cnt       <= '0;
         row       <= '0;
         plane     <= '0;
         front     <= 1'b0;
         pend      <= 1'b0;
         row_sel_q <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         row   <= row_n;
         plane <= plane_n;
         pend  <= frame_end ? 1'b0 : (pend | i_swap_req);
         if (swap_fire) front <= ~front;
         if (state == S_BLANK) row_sel_q <= row;
      end
   end

`ifdef HUB75_BRIGHTNESS_EN
   localparam int PR_W = CNT_W + 8;
   logic [7:0]      bright_q;
   logic [PR_W-1:0] on_prod;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bright_q <= '0;
      end else if (state == S_LATCH &&
                   cnt == CNT_W'(LATCH_CYCLES - 1)) begin
         bright_q <= i_brightness;
      end
   end

   assign on_prod = PR_W'(disp_len) * PR_W'(bright_q);
   assign oe_on   = cnt < CNT_W'(on_prod >> 8);
`else
   assign oe_on = 1'b1;
`endif

   logic [CB-1:0] t_r, t_g, t_b, b_r, b_g, b_b;

   assign t_r = top_q[3*CB-1 -: CB];
   assign t_g = top_q[2*CB-1 -: CB];
   assign t_b = top_q[CB-1:0];
   assign b_r = bot_q[3*CB-1 -: CB];
   assign b_g = bot_q[2*CB-1 -: CB];
   assign b_b = bot_q[CB-1:0];

   assign o_rgb0        = {t_r[plane], t_g[plane], t_b[plane]};
   assign o_rgb1        = {b_r[plane], b_g[plane], b_b[plane]};
   assign o_sclk        = (state == S_SHIFT) && (cnt != '0) && !cnt[0];
   assign o_lat         = (state == S_LATCH);
   assign o_oe          = !((state == S_DISP) && oe_on);
   assign o_row_select  = row_sel_q;
   assign o_swap_ack    = swap_fire;
   assign o_frame_start = (state == S_SHIFT) && (cnt == '0) &&
                          (row == '0) && (plane == '0);

endmodule
